fcc_rpage_buf: RTL



---
 rtl/fcc_rpage_buf_pkg.sv | 28 ++
 rtl/fcc_sdp_ram.sv | 29 ++
 rtl/fcc_rpage_buf.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fcc_rpage_buf_pkg.sv
// rtl/fcc_rpage_buf_pkg.sv - default geometry and stored beat layout for the read-page buffer
package fcc_rpage_buf_pkg;

    localparam int RBUF_DATA_WIDTH     = 32;
    localparam int RBUF_DEPTH_LOG2     = 11;
    localparam int RBUF_PAGE_WORDS     = 1024;
    localparam int RBUF_TAG_DEPTH_LOG2 = 2;
    localparam int RBUF_USER_W         = 4;
    localparam int RBUF_ID_W           = 16;

    // Stored word is {last, user, data}, data in the low bits.
    typedef struct packed {
        logic                       last;
        logic [RBUF_USER_W-1:0]     user;
        logic [RBUF_DATA_WIDTH-1:0] data;
    } rbuf_beat_t;

    function automatic rbuf_beat_t rbuf_pack(input logic                       last,
                                             input logic [RBUF_USER_W-1:0]     user,
                                             input logic [RBUF_DATA_WIDTH-1:0] data);
        rbuf_beat_t b;
        b.last = last;
        b.user = user;
        b.data = data;
        return b;
    endfunction

endpackage

// File: rtl/fcc_sdp_ram.sv
// rtl/fcc_sdp_ram.sv - simple dual-port synchronous RAM with registered read data
module fcc_sdp_ram #(
    parameter int WIDTH  = 37,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [1 << ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fcc_rpage_buf.sv
// rtl/fcc_rpage_buf.sv - NAND read-page buffer with page-ID tags; FCC_RBUF_LEN_CHK_EN adds page-length check
module fcc_rpage_buf
    import fcc_rpage_buf_pkg::*;
#(
    parameter int DATA_WIDTH     = RBUF_DATA_WIDTH,
    parameter int DEPTH_LOG2     = RBUF_DEPTH_LOG2,
    parameter int PAGE_WORDS     = RBUF_PAGE_WORDS,
    parameter int TAG_DEPTH_LOG2 = RBUF_TAG_DEPTH_LOG2
) (
    input  logic                  usr_clk,
    input  logic                  usr_rst_n,
    input  logic                  i_rvalid,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [3:0]            i_ruser,
    input  logic [15:0]           i_rid,
    input  logic                  i_rlast,
    output logic                  o_rpage_buf_ready,
    output logic                  o_dvalid,
    input  logic                  i_dready,
    output logic [DATA_WIDTH-1:0] o_ddata,
    output logic [3:0]            o_duser,
    output logic [15:0]           o_did,
    output logic                  o_dlast,
    output logic [DEPTH_LOG2:0]   o_fill,
    output logic                  o_overflow,
    input  logic                  i_ovf_clr,
    output logic                  o_page_done,
    output logic                  o_len_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TAGS  = 1 << TAG_DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]     FILL_MAX = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]     PAGE_LIM = PAGE_WORDS[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]     ONE_F    = 1;
    localparam logic [TAG_DEPTH_LOG2:0] TAG_FULL = TAGS[TAG_DEPTH_LOG2:0];
    localparam logic [TAG_DEPTH_LOG2:0] ONE_T    = 1;

    logic [DEPTH_LOG2:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill_q, fill_d;
    logic [TAG_DEPTH_LOG2:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [15:0]             tag_mem_q [TAGS];
    logic                    in_page_q, in_page_d, drop_page_q, drop_page_d;
    logic                    s1_q, s1_d, dvalid_q, dvalid_d;
    logic                    ovf_q, ovf_d, rdy_q, rdy_d;
    rbuf_beat_t              dbeat_q, dbeat_d, ram_rbeat;

    logic page_start, full, tag_full, wr_en, tag_push, ovf_set;
    logic xfer, load_out, rd_en, ram_empty;

    assign page_start = !in_page_q;
    assign full       = (fill_q == FILL_MAX);
    assign tag_full   = ((tag_wr_q - tag_rd_q) == TAG_FULL);
    assign ram_empty  = (wr_ptr_q == rd_ptr_q);

    // A page whose first beat cannot be stored loses its tag, so the whole page goes.
    assign tag_push = i_rvalid && page_start && !tag_full && !full;
    assign wr_en    = i_rvalid && !full && (page_start ? !tag_full : !drop_page_q);
    assign ovf_set  = i_rvalid && (page_start ? (tag_full || full) : (!drop_page_q && full));

    // Two-stage read: RAM output register, then the host-facing register.
    assign xfer     = dvalid_q && i_dready;
    assign load_out = s1_q && (!dvalid_q || i_dready);
    assign rd_en    = !ram_empty && (!s1_q || load_out);

    fcc_sdp_ram #(
        .WIDTH  ($bits(rbuf_beat_t)),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (usr_clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (rbuf_pack(i_rlast, i_ruser, i_rdata)),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (ram_rbeat)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        tag_wr_d    = tag_wr_q;
        tag_rd_d    = tag_rd_q;
        in_page_d   = in_page_q;
        drop_page_d = drop_page_q;
        s1_d        = s1_q;
        dvalid_d    = dvalid_q;
        dbeat_d     = dbeat_q;
        ovf_d       = ovf_q;
        rdy_d       = (FILL_MAX - fill_q) >= PAGE_LIM;

        if (i_rvalid) begin
            in_page_d = !i_rlast;
            if (page_start) begin
                drop_page_d = !tag_push && !i_rlast;
            end else if (i_rlast) begin
                drop_page_d = 1'b0;
            end
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE_F;
        end
        if (tag_push) begin
            tag_wr_d = tag_wr_q + ONE_T;
        end
        if (xfer && dbeat_q.last) begin
            tag_rd_d = tag_rd_q + ONE_T;
        end
        if (wr_en && !xfer) begin
            fill_d = fill_q + ONE_F;
        end else if (!wr_en && xfer) begin
            fill_d = fill_q - ONE_F;
        end

        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ONE_F;
            s1_d     = 1'b1;
        end else if (load_out) begin
            s1_d     = 1'b0;
        end
        if (load_out) begin
            dvalid_d = 1'b1;
            dbeat_d  = ram_rbeat;
        end else if (xfer) begin
            dvalid_d = 1'b0;
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            in_page_q   <= 1'b0;
            drop_page_q <= 1'b0;
            s1_q        <= 1'b0;
            dvalid_q    <= 1'b0;
            dbeat_q     <= '0;
            ovf_q       <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            in_page_q   <= in_page_d;
            drop_page_q <= drop_page_d;
            s1_q        <= s1_d;
            dvalid_q    <= dvalid_d;
            dbeat_q     <= dbeat_d;
            ovf_q       <= ovf_d;
            rdy_q       <= rdy_d;
        end
    end

    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            for (int i = 0; i < TAGS; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else if (tag_push) begin
            tag_mem_q[tag_wr_q[TAG_DEPTH_LOG2-1:0]] <= i_rid;
        end
    end

`ifdef FCC_RBUF_LEN_CHK_EN
    localparam int CNT_W = DEPTH_LOG2 + 2;
    localparam logic [CNT_W-1:0] ONE_C   = 1;
    localparam logic [CNT_W-1:0] PAGE_LC = PAGE_WORDS[CNT_W-1:0];

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, cnt_now;
    logic             len_err_q, len_err_d, len_set;

    // Counts every arriving beat of the page, stored or dropped; saturates on runaway pages.
    always_comb begin
        cnt_now    = page_start ? ONE_C
                   : ((&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + ONE_C);
        len_set    = i_rvalid && i_rlast && (cnt_now != PAGE_LC);
        beat_cnt_d = beat_cnt_q;
        if (i_rvalid) begin
            beat_cnt_d = i_rlast ? '0 : cnt_now;
        end
        len_err_d = len_err_q;
        if (len_set) begin
            len_err_d = 1'b1;
        end else if (i_ovf_clr) begin
            len_err_d = 1'b0;
        end
    end

    always_ff @(posedge usr_clk or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign o_len_err = len_err_q;
`else
    assign o_len_err = 1'b0;
`endif

    assign o_rpage_buf_ready = rdy_q;
    assign o_dvalid          = dvalid_q;
    assign o_ddata           = dbeat_q.data;
    assign o_duser           = dbeat_q.user;
    assign o_dlast           = dbeat_q.last;
    assign o_did             = tag_mem_q[tag_rd_q[TAG_DEPTH_LOG2-1:0]];
    assign o_fill            = fill_q;
    assign o_overflow        = ovf_q;
    assign o_page_done       = xfer && dbeat_q.last;

endmodule
